issue_queue: RTL and testbench

Out-of-order issue stage directly upstream of the register-read stage. Buffers renamed instructions carrying physical source and destination tags, and wakes each entry using the busy list produced by register read. Selects the oldest entry whose sources are all non-busy and drives its tags into the physical register-file read ports through a registered issue slot.

---
 rtl/issue_queue_pkg.sv | 24 ++
 rtl/issue_queue_select.sv | 23 ++
 rtl/issue_queue.sv | 153 +++++++++++++++
 tb/tb_issue_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the issue queue.
// Entry layout, tag widths and the occupancy counter width.
package issue_queue_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ENTRIES   = 8;
  localparam int CTRL_WIDTH    = 32;
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS);
  localparam int CNT_W         = $clog2(NUM_ENTRIES + 1);
  localparam int IDX_W         = $clog2(NUM_ENTRIES);

  typedef struct packed {
    logic                  valid;
    logic [LOG_PHYS-1:0]   srcA;
    logic [LOG_PHYS-1:0]   srcB;
    logic [LOG_PHYS-1:0]   srcC;
    logic                  useA;
    logic                  useB;
    logic                  useC;
    logic [LOG_PHYS-1:0]   dest;
    logic [CTRL_WIDTH-1:0] ctrl;
  } iqEntry_t;

endpackage

// File: rtl/issue_queue_select.sv
// Lowest-index-first priority encoder over the ready vector.
// Index 0 is the oldest entry, so this picks the oldest ready one.
module iq_select #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] readyVec,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (readyVec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered compacting issue queue with busy-list wakeup
// and a registered issue slot feeding register read.
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     Flush_IN,
  input  logic                     Enq_Valid_IN,
  output logic                     Enq_Ready_OUT,
  input  logic [LOG_PHYS-1:0]      Enq_SrcA_IN,
  input  logic [LOG_PHYS-1:0]      Enq_SrcB_IN,
  input  logic [LOG_PHYS-1:0]      Enq_SrcC_IN,
  input  logic                     Enq_UseA_IN,
  input  logic                     Enq_UseB_IN,
  input  logic                     Enq_UseC_IN,
  input  logic [LOG_PHYS-1:0]      Enq_Dest_IN,
  input  logic [CTRL_WIDTH-1:0]    Enq_Ctrl_IN,
  input  logic [NUM_PHYS_REGS-1:0] Busy_list_IN,
  input  logic                     Stall_IN,
  output logic                     Issue_Valid_OUT,
  output logic [LOG_PHYS-1:0]      RegAddrA_OUT,
  output logic [LOG_PHYS-1:0]      RegAddrB_OUT,
  output logic [LOG_PHYS-1:0]      RegAddrC_OUT,
  output logic [LOG_PHYS-1:0]      Issue_Dest_OUT,
  output logic [CTRL_WIDTH-1:0]    Issue_Ctrl_OUT,
  output logic [CNT_W-1:0]         Count_OUT
);

  iqEntry_t entries     [NUM_ENTRIES];
  iqEntry_t nextEntries [NUM_ENTRIES];
  iqEntry_t newEntry;
  iqEntry_t selEntry;

  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       nextCount;
  logic [NUM_ENTRIES-1:0] readyVec;
  logic                   selFound;
  logic [IDX_W-1:0]       selIdx;
  logic                   doIssue;
  logic                   doEnq;

  logic                  issValid;
  logic [LOG_PHYS-1:0]   issA;
  logic [LOG_PHYS-1:0]   issB;
  logic [LOG_PHYS-1:0]   issC;
  logic [LOG_PHYS-1:0]   issDest;
  logic [CTRL_WIDTH-1:0] issCtrl;

  assign Enq_Ready_OUT = count < CNT_W'(NUM_ENTRIES);
  assign doIssue = !Stall_IN && selFound;
  assign doEnq   = Enq_Valid_IN && Enq_Ready_OUT;

  assign newEntry = '{
    valid: 1'b1,
    srcA:  Enq_SrcA_IN,
    srcB:  Enq_SrcB_IN,
    srcC:  Enq_SrcC_IN,
    useA:  Enq_UseA_IN,
    useB:  Enq_UseB_IN,
    useC:  Enq_UseC_IN,
    dest:  Enq_Dest_IN,
    ctrl:  Enq_Ctrl_IN
  };

  // An unused source never blocks wakeup.
  always_comb begin
    readyVec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      readyVec[i] = entries[i].valid
        && !(entries[i].useA && Busy_list_IN[entries[i].srcA])
        && !(entries[i].useB && Busy_list_IN[entries[i].srcB])
        && !(entries[i].useC && Busy_list_IN[entries[i].srcC]);
    end
  end

  iq_select #(
    .N (NUM_ENTRIES),
    .W (IDX_W)
  ) uSelect (
    .readyVec (readyVec),
    .found    (selFound),
    .idx      (selIdx)
  );

  assign selEntry = entries[selIdx];

  // Remove-then-append keeps index 0 the oldest.
  always_comb begin
    nextEntries = entries;
    nextCount   = count;
    if (doIssue) begin
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
        if (IDX_W'(i) >= selIdx) begin
          nextEntries[i] = entries[i+1];
        end
      end
      nextEntries[NUM_ENTRIES-1] = '0;
      nextCount = count - 1'b1;
    end
    if (doEnq) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (CNT_W'(i) == nextCount) begin
          nextEntries[i] = newEntry;
        end
      end
      nextCount = nextCount + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      count    <= '0;
      issValid <= 1'b0;
      issA     <= '0;
      issB     <= '0;
      issC     <= '0;
      issDest  <= '0;
      issCtrl  <= '0;
    end else if (Flush_IN) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      count    <= '0;
      issValid <= 1'b0;
    end else begin
      entries <= nextEntries;
      count   <= nextCount;
      if (!Stall_IN) begin
        issValid <= selFound;
        if (selFound) begin
          issA    <= selEntry.srcA;
          issB    <= selEntry.srcB;
          issC    <= selEntry.srcC;
          issDest <= selEntry.dest;
          issCtrl <= selEntry.ctrl;
        end
      end
    end
  end

  assign Issue_Valid_OUT = issValid;
  assign RegAddrA_OUT    = issA;
  assign RegAddrB_OUT    = issB;
  assign RegAddrC_OUT    = issC;
  assign Issue_Dest_OUT  = issDest;
  assign Issue_Ctrl_OUT  = issCtrl;
  assign Count_OUT       = count;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_issue_queue;

  logic        CLK;
  logic        RESET;
  logic        Flush_IN;
  logic        Enq_Valid_IN;
  logic        Enq_Ready_OUT;
  logic [5:0]  Enq_SrcA_IN, Enq_SrcB_IN, Enq_SrcC_IN;
  logic        Enq_UseA_IN, Enq_UseB_IN, Enq_UseC_IN;
  logic [5:0]  Enq_Dest_IN;
  logic [31:0] Enq_Ctrl_IN;
  logic [63:0] Busy_list_IN;
  logic        Stall_IN;
  logic        Issue_Valid_OUT;
  logic [5:0]  RegAddrA_OUT, RegAddrB_OUT, RegAddrC_OUT;
  logic [5:0]  Issue_Dest_OUT;
  logic [31:0] Issue_Ctrl_OUT;
  logic [3:0]  Count_OUT;

  issue_queue dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .Flush_IN        (Flush_IN),
    .Enq_Valid_IN    (Enq_Valid_IN),
    .Enq_Ready_OUT   (Enq_Ready_OUT),
    .Enq_SrcA_IN     (Enq_SrcA_IN),
    .Enq_SrcB_IN     (Enq_SrcB_IN),
    .Enq_SrcC_IN     (Enq_SrcC_IN),
    .Enq_UseA_IN     (Enq_UseA_IN),
    .Enq_UseB_IN     (Enq_UseB_IN),
    .Enq_UseC_IN     (Enq_UseC_IN),
    .Enq_Dest_IN     (Enq_Dest_IN),
    .Enq_Ctrl_IN     (Enq_Ctrl_IN),
    .Busy_list_IN    (Busy_list_IN),
    .Stall_IN        (Stall_IN),
    .Issue_Valid_OUT (Issue_Valid_OUT),
    .RegAddrA_OUT    (RegAddrA_OUT),
    .RegAddrB_OUT    (RegAddrB_OUT),
    .RegAddrC_OUT    (RegAddrC_OUT),
    .Issue_Dest_OUT  (Issue_Dest_OUT),
    .Issue_Ctrl_OUT  (Issue_Ctrl_OUT),
    .Count_OUT       (Count_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [5:0]  a, b, c;
    logic        ua, ub, uc;
    logic [5:0]  d;
    logic [31:0] ctrl;
  } mEnt_t;

  mEnt_t mq[$];
  mEnt_t slot;
  bit    slotValid;
  int    nChecks = 0;
  int    nFail   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit entReady(input mEnt_t e);
    return !(e.ua && Busy_list_IN[e.a]) && !(e.ub && Busy_list_IN[e.b])
        && !(e.uc && Busy_list_IN[e.c]);
  endfunction

  task automatic clearSlot();
    slot = '{a: 0, b: 0, c: 0, ua: 0, ub: 0, uc: 0, d: 0, ctrl: 0};
    slotValid = 0;
  endtask

  task automatic checkOutputs(input string tag);
    check({tag, ".count"}, 64'(Count_OUT), 64'(mq.size()));
    check({tag, ".valid"}, 64'(Issue_Valid_OUT), 64'(slotValid));
    check({tag, ".addrA"}, 64'(RegAddrA_OUT), 64'(slot.a));
    check({tag, ".addrB"}, 64'(RegAddrB_OUT), 64'(slot.b));
    check({tag, ".addrC"}, 64'(RegAddrC_OUT), 64'(slot.c));
    check({tag, ".dest"}, 64'(Issue_Dest_OUT), 64'(slot.d));
    check({tag, ".ctrl"}, 64'(Issue_Ctrl_OUT), 64'(slot.ctrl));
  endtask

  // Predict the edge from current inputs, then clock and compare.
  task automatic tick(input string tag);
    bit    rdy;
    int    found;
    mEnt_t e;
    rdy = mq.size() < 8;
    check({tag, ".enqReady"}, 64'(Enq_Ready_OUT), 64'(rdy));
    e = '{a: Enq_SrcA_IN, b: Enq_SrcB_IN, c: Enq_SrcC_IN,
          ua: Enq_UseA_IN, ub: Enq_UseB_IN, uc: Enq_UseC_IN,
          d: Enq_Dest_IN, ctrl: Enq_Ctrl_IN};
    if (Flush_IN) begin
      mq.delete();
      slotValid = 0;
    end else begin
      if (!Stall_IN) begin
        found = -1;
        foreach (mq[i]) if (found < 0 && entReady(mq[i])) found = i;
        if (found >= 0) begin
          slot = mq[found];
          mq.delete(found);
          slotValid = 1;
        end else begin
          slotValid = 0;
        end
      end
      if (Enq_Valid_IN && rdy) mq.push_back(e);
    end
    @(posedge CLK);
    #1;
    checkOutputs(tag);
  endtask

  task automatic setEnq(input logic [5:0] a, b, c, input logic ua, ub, uc,
                        input logic [5:0] d, input logic [31:0] ctrl);
    Enq_Valid_IN = 1; Enq_SrcA_IN = a; Enq_SrcB_IN = b; Enq_SrcC_IN = c;
    Enq_UseA_IN = ua; Enq_UseB_IN = ub; Enq_UseC_IN = uc;
    Enq_Dest_IN = d; Enq_Ctrl_IN = ctrl;
  endtask

  task automatic enq(input string tag, input logic [5:0] a, b, c,
                     input logic ua, ub, uc, input logic [5:0] d,
                     input logic [31:0] ctrl);
    setEnq(a, b, c, ua, ub, uc, d, ctrl);
    tick(tag);
    Enq_Valid_IN = 0;
  endtask

  initial begin
    RESET = 0; Flush_IN = 0; Stall_IN = 0; Busy_list_IN = '0;
    Enq_Valid_IN = 0; Enq_SrcA_IN = 0; Enq_SrcB_IN = 0; Enq_SrcC_IN = 0;
    Enq_UseA_IN = 0; Enq_UseB_IN = 0; Enq_UseC_IN = 0;
    Enq_Dest_IN = 0; Enq_Ctrl_IN = 0;
    clearSlot();
    #3;
    checkOutputs("reset");
    #4 RESET = 1;
    #1;
    check("resetReady", 64'(Enq_Ready_OUT), 64'd1);

    // Basic two-edge enqueue-to-issue latency
    enq("basicAccept", 6'd5, 6'd9, 6'd0, 1, 1, 0, 6'd20, 32'hA5A5_0001);
    check("basicNotYet", 64'(Issue_Valid_OUT), 64'd0);
    tick("basicIssue");
    check("basicValid", 64'(Issue_Valid_OUT), 64'd1);
    check("basicA", 64'(RegAddrA_OUT), 64'd5);
    check("basicB", 64'(RegAddrB_OUT), 64'd9);
    tick("basicDrain");

    // Younger ready entry bypasses an older blocked one
    Busy_list_IN[12] = 1;
    enq("wakeE0", 6'd12, 6'd0, 6'd0, 1, 0, 0, 6'd30, 32'h0000_0E00);
    enq("wakeE1", 6'd1, 6'd2, 6'd0, 1, 1, 0, 6'd31, 32'h0000_0E01);
    tick("wakeFirst");
    check("wakeFirstDest", 64'(Issue_Dest_OUT), 64'd31);
    Busy_list_IN[12] = 0;
    tick("wakeSecond");
    check("wakeSecondDest", 64'(Issue_Dest_OUT), 64'd30);
    tick("wakeDrain");

    // Fill to capacity; ninth enqueue refused
    Busy_list_IN[3] = 1;
    for (int i = 0; i < 8; i++)
      enq("fill", 6'd3, 6'd0, 6'd0, 1, 0, 0, 6'(40 + i), 32'(i));
    check("fullCount", 64'(Count_OUT), 64'd8);
    check("fullReady", 64'(Enq_Ready_OUT), 64'd0);
    enq("fillReject", 6'd7, 6'd0, 6'd0, 1, 0, 0, 6'd63, 32'hDEAD);
    Busy_list_IN[3] = 0;
    for (int i = 0; i < 8; i++) begin
      tick("drainOrder");
      check("drainDest", 64'(Issue_Dest_OUT), 64'(40 + i));
    end
    tick("drainEmpty");

    // Stall freezes the slot but still accepts enqueues
    enq("stallX", 6'd4, 6'd0, 6'd0, 1, 0, 0, 6'd50, 32'h5001);
    enq("stallY", 6'd6, 6'd0, 6'd0, 1, 0, 0, 6'd51, 32'h5002);
    Stall_IN = 1;
    for (int i = 0; i < 3; i++) begin
      tick("stallHold");
      check("stallDest", 64'(Issue_Dest_OUT), 64'd50);
      check("stallCount", 64'(Count_OUT), 64'd1);
    end
    Stall_IN = 0;
    tick("stallRelease");
    check("stallNext", 64'(Issue_Dest_OUT), 64'd51);
    tick("stallDrain");

    // Flush beats a simultaneous enqueue
    Busy_list_IN[3] = 1;
    for (int i = 0; i < 4; i++)
      enq("flushFill", 6'd3, 6'd0, 6'd0, 1, 0, 0, 6'(10 + i), 32'(i));
    setEnq(6'd1, 6'd0, 6'd0, 1, 0, 0, 6'd60, 32'hF1);
    Flush_IN = 1;
    tick("flush");
    Flush_IN = 0; Enq_Valid_IN = 0;
    check("flushCount", 64'(Count_OUT), 64'd0);
    check("flushValid", 64'(Issue_Valid_OUT), 64'd0);
    Busy_list_IN = '0;
    tick("flushAfter");

    // Asynchronous reset with entries queued and a valid slot
    Busy_list_IN[3] = 1;
    enq("arR", 6'd8, 6'd0, 6'd0, 1, 0, 0, 6'd21, 32'hAA);
    enq("arB1", 6'd3, 6'd0, 6'd0, 1, 0, 0, 6'd22, 32'hB1);
    Stall_IN = 1;
    enq("arB2", 6'd3, 6'd0, 6'd0, 1, 0, 0, 6'd23, 32'hB2);
    enq("arB3", 6'd3, 6'd0, 6'd0, 1, 0, 0, 6'd24, 32'hB3);
    check("arPreCount", 64'(Count_OUT), 64'd3);
    check("arPreValid", 64'(Issue_Valid_OUT), 64'd1);
    #3 RESET = 0;
    #1;
    mq.delete();
    clearSlot();
    checkOutputs("asyncReset");
    #2 RESET = 1;
    Stall_IN = 0;
    Busy_list_IN = '0;

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      Busy_list_IN = {$urandom, $urandom} & {$urandom, $urandom}
                   & {$urandom, $urandom};
      Stall_IN = ($urandom_range(0, 4) == 0);
      Flush_IN = ($urandom_range(0, 39) == 0);
      setEnq(6'($urandom), 6'($urandom), 6'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             6'($urandom), $urandom);
      Enq_Valid_IN = 1'($urandom);
      tick("random");
    end
    Flush_IN = 0; Stall_IN = 0; Enq_Valid_IN = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
